vernam_decipher_rx: RTL
=======================

Name: vernam_decipher_rx

Overview:
- Receive-side counterpart of the Vernam encryption pair.
- A PicoBlaze (or equivalent port master) writes ciphertext and key bytes through the standard KCPSM3 port interface.
- The block pairs each cipher byte with its key byte, XORs them, and queues the plaintext in a small FIFO. The FIFO drains on a valid/ready stream.
- The block raises a set/ack interrupt each time a pair is consumed, so the master can send the next pair.

Parameters:
FIFO_DEPTH, 4, plaintext FIFO entries; power of two, 2..16
FIFO_AW, 2, log2(FIFO_DEPTH); must be consistent with FIFO_DEPTH

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
port_id  input  8  KCPSM3 port address
out_port  input  8  KCPSM3 write data
write_strobe  input  1  KCPSM3 write strobe, one cycle
read_strobe  input  1  KCPSM3 read strobe, one cycle
in_port  output  8  registered status byte for KCPSM3 INPUT
interrupt  output  1  pair-consumed interrupt, level
interrupt_ack  input  1  KCPSM3 interrupt acknowledge
pt_data  output  8  plaintext byte at FIFO head (first-word fall-through)
pt_valid  output  1  FIFO non-empty
pt_ready  input  1  sink accepts pt_data when pt_valid & pt_ready

Behaviour:
- Reset (clk is the only clock; reset is synchronous, active-high):
  - state=EMPTY; cipher/key holding registers = 0x00; FIFO empty (count 0, pointers 0).
  - pt_valid=0; pt_data=0x00; interrupt=0; in_port=0x00; sticky flags cleared.
  - Reset asserted mid-pair discards any held byte and all FIFO contents.
- Write decode: wr = write_strobe & port_id[3].
  - port_id[0]=0: cipher byte (port 0x08).
  - port_id[0]=1: key byte (port 0x09).
  - Other bits are ignored.
- Pairing FSM states: EMPTY, HAVE_C, HAVE_K, PAIRED.
  - EMPTY: cipher write -> HAVE_C; key write -> HAVE_K.
  - HAVE_C: cipher write overwrites the held cipher byte and stays in HAVE_C. Key write -> PAIRED, result <= cipher ^ out_port.
  - HAVE_K: symmetric to HAVE_C.
  - PAIRED: if FIFO count < FIFO_DEPTH, push result and go to EMPTY. Otherwise hold in PAIRED.
  - Any write while in PAIRED is dropped and sets the sticky overrun flag. This includes the cycle in which the push happens.
- Latency: with the completing write sampled at edge E, state is PAIRED after E, the push occurs at E+1, and pt_valid=1 after E+1 if the FIFO was empty. There is no bypass path.
- FIFO:
  - Push and pop in the same cycle are allowed when 0 < count < DEPTH; count is unchanged.
  - When full, the push is blocked even if a pop occurs in the same cycle; the push retries next cycle.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - pt_data must be stable while pt_valid=1 and pt_ready=0.
- Interrupt:
  - Set on each FIFO push from PAIRED.
  - Cleared by interrupt_ack. If ack and set occur in the same cycle, ack wins and that event is lost (matches the encryption-side interrupt DFF).
- Status read:
  - in_port is registered every cycle, independent of strobe: status when port_id[7]=1, else 0x00.
  - Status bits: [7] zero_key_err, [6] overrun, [5] fifo_full, [4] fifo_empty, [3] state==HAVE_K, [2] state==HAVE_C, [1:0] 0.
  - read_strobe & port_id[7] clears bits 7:6 at that edge. If a new error event occurs in the same cycle, set wins.

Optional Feature:
- Macro: VERNAM_ZERO_KEY_CHECK_EN.
- Defined: a key byte of 0x00 completing a pair is treated as insecure.
  - The pair is discarded: no FIFO push and no interrupt. State returns to EMPTY directly.
  - Status bit 7 (zero_key_err) is set sticky.
- Undefined: key 0x00 is processed normally (plaintext = cipher). Status bit 7 always reads 0.

Test Plan:
- Reset, then write 0x5A to port 0x08 and 0x3C to port 0x09 -> pt_valid rises 2 edges after the key write, pt_data=0x66, interrupt=1 until interrupt_ack.
- Key-first ordering: key 0xFF then cipher 0x0F -> pt_data=0xF0. Second cipher write 0x11 while in HAVE_C after key 0xAA -> the overwrite rule applies and the latest cipher is used.
- Hold pt_ready=0 and send 5 pairs with FIFO_DEPTH=4 -> 4 pushed, state stuck in PAIRED, status=0x20|... with fifo_full=1. A further write sets overrun (status bit 6). Raise pt_ready -> 5 bytes drain in order, then read status with read_strobe -> bit 6 cleared.
- Simultaneous interrupt_ack and push -> interrupt stays 0. Verify read-clear versus overrun-set in the same cycle -> bit 6 remains 1.
- Assert reset while in HAVE_C with 2 FIFO entries -> pt_valid=0 and status reads 0x10 next cycle. A new pair 0x01/0x02 yields 0x03.
- With VERNAM_ZERO_KEY_CHECK_EN: cipher 0x77, key 0x00 -> no pt_valid, no interrupt, status bit 7=1, state EMPTY. Without the macro: pt_data=0x77.

Source files
------------

// File: rtl/vernam_decipher_rx_if.sv
// KCPSM3 port bus and plaintext stream bundle for vernam_decipher_rx.
// The master modport is the environment side: port master plus plaintext sink.
interface vernam_decipher_rx_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_ready;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack, pt_ready,
    input  in_port, interrupt, pt_data, pt_valid
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack, pt_ready,
    output in_port, interrupt, pt_data, pt_valid
  );
endinterface

// File: rtl/vernam_decipher_rx.sv
// Vernam receive side: pairs cipher/key bytes written over KCPSM3 ports, XORs them into a plaintext FIFO.
// Optional macro VERNAM_ZERO_KEY_CHECK_EN discards pairs whose key byte is 0x00 and flags them.
module vernam_decipher_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  vernam_decipher_rx_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY, HAVE_C, HAVE_K, PAIRED} state_e;

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

  state_e             state_q;
  logic [7:0]         cipher_q;
  logic [7:0]         key_q;
  logic [7:0]         result_q;
  logic [7:0]         fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overrun_q;
  logic               zero_key_q;
  logic               irq_q;
  logic [7:0]         in_port_q;

  logic       wr, wr_key, wr_cipher;
  logic       fifo_full, fifo_empty, push, pop;
  logic       status_clr, overrun_set, zero_key_set, pair_done;
  logic [7:0] pair_cipher, pair_key, status;

  assign wr         = bus.write_strobe & bus.port_id[3];
  assign wr_key     = wr & bus.port_id[0];
  assign wr_cipher  = wr & ~bus.port_id[0];
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = (state_q == PAIRED) & ~fifo_full;
  assign pop        = bus.pt_ready & ~fifo_empty;
  assign status_clr = bus.read_strobe & bus.port_id[7];
  // The push cycle itself still counts as PAIRED, so a write there is dropped too.
  assign overrun_set = (state_q == PAIRED) & wr;

  always_comb begin
    pair_done   = ((state_q == HAVE_C) & wr_key) | ((state_q == HAVE_K) & wr_cipher);
    pair_cipher = (state_q == HAVE_C) ? cipher_q : bus.out_port;
    pair_key    = (state_q == HAVE_C) ? bus.out_port : key_q;
  end

`ifdef VERNAM_ZERO_KEY_CHECK_EN
  assign zero_key_set = pair_done & (pair_key == 8'h00);
`else
  assign zero_key_set = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      cipher_q <= 8'h00;
      key_q    <= 8'h00;
      result_q <= 8'h00;
    end else begin
      case (state_q)
        EMPTY: begin
          if (wr_cipher) begin
            cipher_q <= bus.out_port;
            state_q  <= HAVE_C;
          end else if (wr_key) begin
            key_q   <= bus.out_port;
            state_q <= HAVE_K;
          end
        end
        HAVE_C: begin
          if (wr_cipher) begin
            cipher_q <= bus.out_port;
          end else if (wr_key) begin
            key_q    <= bus.out_port;
            result_q <= pair_cipher ^ pair_key;
            state_q  <= zero_key_set ? EMPTY : PAIRED;
          end
        end
        HAVE_K: begin
          if (wr_key) begin
            key_q <= bus.out_port;
          end else if (wr_cipher) begin
            cipher_q <= bus.out_port;
            result_q <= pair_cipher ^ pair_key;
            state_q  <= zero_key_set ? EMPTY : PAIRED;
          end
        end
        PAIRED: begin
          if (!fifo_full) state_q <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign status = {zero_key_q, overrun_q, fifo_full, fifo_empty,
                   state_q == HAVE_K, state_q == HAVE_C, 2'b00};

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q  <= 1'b0;
      zero_key_q <= 1'b0;
      irq_q      <= 1'b0;
      in_port_q  <= 8'h00;
    end else begin
      overrun_q  <= overrun_set  | (overrun_q  & ~status_clr);
      zero_key_q <= zero_key_set | (zero_key_q & ~status_clr);
      if (bus.interrupt_ack) irq_q <= 1'b0;
      else if (push)         irq_q <= 1'b1;
      in_port_q  <= bus.port_id[7] ? status : 8'h00;
    end
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_q;
  assign bus.pt_valid  = ~fifo_empty;
  assign bus.pt_data   = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];
endmodule
